// File: rtl/tinygpu_mem_pkg.sv
// tinygpu_mem_pkg: shared DataMemory widths, lane count and sequencer state encoding
package tinygpu_mem_pkg;
  localparam int DATA_WORD_LENGTH = 16;
  localparam int DATAMEM_ADDR_WIDTH = 16;
  localparam int NUM_LANES_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} seq_state_e;
endpackage

// File: rtl/lane_mem_sequencer_if.sv
// lane_mem_sequencer_if: vector request/response handshake plus DataMemory port
interface lane_mem_sequencer_if import tinygpu_mem_pkg::*; #(
  parameter int NUM_LANES = NUM_LANES_DEFAULT,
  parameter int ADDR_WIDTH = DATAMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DATA_WORD_LENGTH
);
  logic ReqValid;
  logic ReqReady;
  logic ReqWrite;
  logic [NUM_LANES-1:0] ReqMask;
  logic [NUM_LANES*ADDR_WIDTH-1:0] ReqAddr;
  logic [NUM_LANES*DATA_WIDTH-1:0] ReqWData;
  logic RespValid;
  logic RespReady;
  logic [NUM_LANES*DATA_WIDTH-1:0] RespData;
  logic MemWrite;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic [DATA_WIDTH-1:0] MemReadData;
  modport slave (
    input ReqValid, ReqWrite, ReqMask, ReqAddr, ReqWData, RespReady, MemReadData,
    output ReqReady, RespValid, RespData, MemWrite, MemAddress, MemWriteData
  );
  modport master (
    output ReqValid, ReqWrite, ReqMask, ReqAddr, ReqWData, RespReady, MemReadData,
    input ReqReady, RespValid, RespData, MemWrite, MemAddress, MemWriteData
  );
endinterface

// File: rtl/lane_mem_sequencer.sv
// lane_mem_sequencer: serialises one vector load/store into one DataMemory access per lane per cycle
module lane_mem_sequencer import tinygpu_mem_pkg::*; #(
  parameter int NUM_LANES = NUM_LANES_DEFAULT,
  parameter int ADDR_WIDTH = DATAMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DATA_WORD_LENGTH
) (
  input logic clk,
  input logic reset,
  lane_mem_sequencer_if.slave bus
);
  localparam int LW = $clog2(NUM_LANES);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP = RESP;
  logic [1:0] r_state;
  logic r_write;
  logic [NUM_LANES-1:0] r_mask;
  logic [NUM_LANES*ADDR_WIDTH-1:0] r_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_wdata;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_rdata;
  logic [LW-1:0] r_lane;
  logic w_access;
  logic w_last;
  assign w_access = r_state == S_ACCESS;
  assign w_last = r_lane == LW'(NUM_LANES - 1);
  assign bus.ReqReady = r_state == S_IDLE;
  assign bus.RespValid = r_state == S_RESP;
  assign bus.RespData = r_rdata;
  // Mem outputs decode straight from state so an async reset silences writes at once
  assign bus.MemWrite = w_access & r_write & r_mask[r_lane];
  assign bus.MemAddress = w_access ? r_addr[r_lane*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.MemWriteData = w_access ? r_wdata[r_lane*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_mask <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_lane <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.ReqValid) begin
        r_write <= bus.ReqWrite;
        r_mask <= bus.ReqMask;
        r_addr <= bus.ReqAddr;
        r_wdata <= bus.ReqWData;
        r_rdata <= '0;
        r_lane <= '0;
        r_state <= bus.ReqMask == '0 ? S_RESP : S_ACCESS;
      end
    end else if (r_state == S_ACCESS) begin
      if (!r_write && r_mask[r_lane])
        r_rdata[r_lane*DATA_WIDTH +: DATA_WIDTH] <= bus.MemReadData;
      if (w_last)
        r_state <= S_RESP;
      else
        r_lane <= r_lane + 1'b1;
    end else if (bus.RespReady) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_lane_mem_sequencer.sv
// tb_lane_mem_sequencer: directed checks of the lane sequencer against a behavioural DataMemory
module tb_lane_mem_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] mem [0:65535];
  lane_mem_sequencer_if bus();
  lane_mem_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.MemReadData = mem[bus.MemAddress];
  always @(posedge clk) if (bus.MemWrite) mem[bus.MemAddress] <= bus.MemWriteData;

  task automatic issue(input logic w, input logic [3:0] m, input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.ReqValid = 1'b1;
    bus.ReqWrite = w;
    bus.ReqMask = m;
    bus.ReqAddr = a;
    bus.ReqWData = d;
    @(negedge clk);
    bus.ReqValid = 1'b0;
    bus.ReqWrite = 1'b0;
    bus.ReqMask = '0;
    bus.ReqAddr = '0;
    bus.ReqWData = '0;
  endtask

  task automatic ack();
    bus.RespReady = 1'b1;
    @(negedge clk);
    bus.RespReady = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) reset = 1'b0;
      total++; if (bus.ReqReady !== 1'b1) begin bad++; $display("FAIL reset_ReqReady c=%0d got %b want 1", c, bus.ReqReady); end
      total++; if (bus.RespValid !== 1'b0) begin bad++; $display("FAIL reset_RespValid c=%0d got %b want 0", c, bus.RespValid); end
      total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL reset_MemWrite c=%0d got %b want 0", c, bus.MemWrite); end
      total++; if (bus.MemAddress !== 16'h0) begin bad++; $display("FAIL reset_MemAddress c=%0d got %h want 0", c, bus.MemAddress); end
      total++; if (bus.MemWriteData !== 16'h0) begin bad++; $display("FAIL reset_MemWriteData c=%0d got %h want 0", c, bus.MemWriteData); end
      total++; if (bus.RespData !== 64'h0) begin bad++; $display("FAIL reset_RespData c=%0d got %h want 0", c, bus.RespData); end
    end
  endtask

  task automatic test_store_load();
    issue(1'b1, 4'hF, {16'h13, 16'h12, 16'h11, 16'h10}, {16'hA003, 16'hA002, 16'hA001, 16'hA000});
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.MemWrite !== 1'b1) begin bad++; $display("FAIL store_MemWrite lane=%0d got %b want 1", i, bus.MemWrite); end
      total++; if (bus.MemAddress !== 16'(16'h10 + i)) begin bad++; $display("FAIL store_MemAddress lane=%0d got %h want %h", i, bus.MemAddress, 16'(16'h10 + i)); end
      total++; if (bus.MemWriteData !== 16'(16'hA000 + i)) begin bad++; $display("FAIL store_MemWriteData lane=%0d got %h want %h", i, bus.MemWriteData, 16'(16'hA000 + i)); end
      total++; if (bus.RespValid !== 1'b0 || bus.ReqReady !== 1'b0) begin bad++; $display("FAIL store_busy lane=%0d got RespValid=%b ReqReady=%b want 0 0", i, bus.RespValid, bus.ReqReady); end
      @(negedge clk);
    end
    total++; if (bus.RespValid !== 1'b1) begin bad++; $display("FAIL store_RespValid got %b want 1", bus.RespValid); end
    total++; if (bus.RespData !== 64'h0) begin bad++; $display("FAIL store_RespData got %h want 0", bus.RespData); end
    ack();
    total++; if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin bad++; $display("FAIL store_idle got ReqReady=%b RespValid=%b want 1 0", bus.ReqReady, bus.RespValid); end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[16'h10 + i] !== 16'(16'hA000 + i)) begin bad++; $display("FAIL store_mem addr=%h got %h want %h", 16'h10 + i, mem[16'h10 + i], 16'(16'hA000 + i)); end
    end
    issue(1'b0, 4'hF, {16'h13, 16'h12, 16'h11, 16'h10}, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL load_MemWrite lane=%0d got %b want 0", i, bus.MemWrite); end
      total++; if (bus.MemAddress !== 16'(16'h10 + i)) begin bad++; $display("FAIL load_MemAddress lane=%0d got %h want %h", i, bus.MemAddress, 16'(16'h10 + i)); end
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      total++; if (bus.RespValid !== 1'b1) begin bad++; $display("FAIL load_RespValid c=%0d got %b want 1", c, bus.RespValid); end
      total++; if (bus.RespData !== 64'hA003_A002_A001_A000) begin bad++; $display("FAIL load_RespData c=%0d got %h want A003A002A001A000", c, bus.RespData); end
      if (c == 0) @(negedge clk);
    end
    ack();
  endtask

  task automatic test_masked_load();
    issue(1'b1, 4'hF, {16'h43, 16'h42, 16'h41, 16'h40}, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    repeat (4) @(negedge clk);
    ack();
    issue(1'b0, 4'b0101, {16'h43, 16'h42, 16'h41, 16'h40}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL masked_MemWrite lane=%0d got %b want 0", i, bus.MemWrite); end
      total++; if (bus.MemAddress !== 16'(16'h40 + i)) begin bad++; $display("FAIL masked_MemAddress lane=%0d got %h want %h", i, bus.MemAddress, 16'(16'h40 + i)); end
      @(negedge clk);
    end
    total++; if (bus.RespValid !== 1'b1) begin bad++; $display("FAIL masked_RespValid got %b want 1", bus.RespValid); end
    total++; if (bus.RespData !== 64'h0000_3333_0000_1111) begin bad++; $display("FAIL masked_RespData got %h want 0000333300001111", bus.RespData); end
    ack();
  endtask

  task automatic test_empty_backpressure();
    issue(1'b1, 4'h0, {16'h53, 16'h52, 16'h51, 16'h50}, {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD});
    for (int c = 0; c < 5; c++) begin
      bus.ReqValid = 1'b1;
      bus.ReqWrite = 1'b1;
      bus.ReqMask = 4'hF;
      bus.ReqAddr = {16'h53, 16'h52, 16'h51, 16'h50};
      total++; if (bus.RespValid !== 1'b1) begin bad++; $display("FAIL empty_RespValid c=%0d got %b want 1", c, bus.RespValid); end
      total++; if (bus.RespData !== 64'h0) begin bad++; $display("FAIL empty_RespData c=%0d got %h want 0", c, bus.RespData); end
      total++; if (bus.ReqReady !== 1'b0) begin bad++; $display("FAIL empty_ReqReady c=%0d got %b want 0", c, bus.ReqReady); end
      total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL empty_MemWrite c=%0d got %b want 0", c, bus.MemWrite); end
      @(negedge clk);
    end
    bus.ReqValid = 1'b0;
    bus.ReqMask = '0;
    total++; if (bus.RespValid !== 1'b1) begin bad++; $display("FAIL empty_held got %b want 1", bus.RespValid); end
    ack();
    total++; if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin bad++; $display("FAIL empty_release got ReqReady=%b RespValid=%b want 1 0", bus.ReqReady, bus.RespValid); end
  endtask

  task automatic test_duplicate_store();
    issue(1'b1, 4'hF, {16'h20, 16'h20, 16'h20, 16'h20}, {16'h4, 16'h3, 16'h2, 16'h1});
    repeat (4) @(negedge clk);
    ack();
    issue(1'b0, 4'b0001, {16'h20, 16'h20, 16'h20, 16'h20}, 64'h0);
    repeat (4) @(negedge clk);
    total++; if (bus.RespData !== 64'h0000_0000_0000_0004) begin bad++; $display("FAIL dup_RespData got %h want 0000000000000004", bus.RespData); end
    ack();
  endtask

  task automatic test_reset_mid_batch();
    issue(1'b1, 4'hF, {16'h33, 16'h32, 16'h31, 16'h30}, {16'h5553, 16'h5552, 16'h5551, 16'h5550});
    repeat (4) @(negedge clk);
    ack();
    issue(1'b1, 4'hF, {16'h33, 16'h32, 16'h31, 16'h30}, {16'h7773, 16'h7772, 16'h7771, 16'h7770});
    repeat (2) @(negedge clk);
    total++; if (bus.MemWrite !== 1'b1 || bus.MemAddress !== 16'h32) begin bad++; $display("FAIL mid_lane2 got MemWrite=%b MemAddress=%h want 1 0032", bus.MemWrite, bus.MemAddress); end
    #1 reset = 1'b1;
    #1;
    total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL mid_MemWrite_drop got %b want 0", bus.MemWrite); end
    total++; if (bus.MemAddress !== 16'h0 || bus.ReqReady !== 1'b1) begin bad++; $display("FAIL mid_abort got MemAddress=%h ReqReady=%b want 0000 1", bus.MemAddress, bus.ReqReady); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin bad++; $display("FAIL mid_idle got ReqReady=%b RespValid=%b want 1 0", bus.ReqReady, bus.RespValid); end
    total++; if (mem[16'h30] !== 16'h7770) begin bad++; $display("FAIL mid_mem30 got %h want 7770", mem[16'h30]); end
    total++; if (mem[16'h31] !== 16'h7771) begin bad++; $display("FAIL mid_mem31 got %h want 7771", mem[16'h31]); end
    total++; if (mem[16'h32] !== 16'h5552) begin bad++; $display("FAIL mid_mem32 got %h want 5552", mem[16'h32]); end
    total++; if (mem[16'h33] !== 16'h5553) begin bad++; $display("FAIL mid_mem33 got %h want 5553", mem[16'h33]); end
  endtask

  initial begin
    bus.ReqValid = 1'b0;
    bus.ReqWrite = 1'b0;
    bus.ReqMask = '0;
    bus.ReqAddr = '0;
    bus.ReqWData = '0;
    bus.RespReady = 1'b0;
    test_reset();
    test_store_load();
    test_masked_load();
    test_empty_backpressure();
    test_duplicate_store();
    test_reset_mid_batch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lane_mem_sequencer.md
# lane_mem_sequencer

Multi-lane load/store sequencer that sits between the SIMD execution lanes and the single-port DataMemory. It accepts one vector request (all-read or all-write, per-lane address, data and mask) and serialises it into one DataMemory access per lane per cycle. DataMemory reads are combinational and its writes commit on the clock edge. Read results are gathered into a response vector and returned with a valid/ready handshake.

## Interface
Parameters:
- NUM_LANES, 4, lanes per request (≥2)
- ADDR_WIDTH, 16, DataMemory address width
- DATA_WIDTH, 16, data word width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  sequencer can accept a request
- ReqWrite  in  1  1 = store batch, 0 = load batch
- ReqMask  in  NUM_LANES  per-lane enable; bit i = lane i
- ReqAddr  in  NUM_LANES*ADDR_WIDTH  lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ReqWData  in  NUM_LANES*DATA_WIDTH  lane i store data
- RespValid  out  1  batch complete; RespData valid for loads
- RespReady  in  1  consumer accepts response
- RespData  out  NUM_LANES*DATA_WIDTH  gathered load data, lane-packed like ReqWData
- MemWrite  out  1  to DataMemory MemWrite
- MemAddress  out  ADDR_WIDTH  to DataMemory Address
- MemWriteData  out  DATA_WIDTH  to DataMemory WriteData
- MemReadData  in  DATA_WIDTH  from DataMemory ReadData

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: ReqReady=1. On ReqValid the sequencer does the following:
  - latches ReqWrite, ReqMask, ReqAddr and ReqWData;
  - clears RespData to 0;
  - sets lane counter to 0.
  - Next state: RESP if ReqMask==0, otherwise ACCESS.
- ACCESS, lane counter i:
  - Drives MemAddress=addr[i] and MemWriteData=wdata[i].
  - Drives MemWrite = write_q & mask_q[i].
  - For a load with mask_q[i]=1, MemReadData is captured into RespData lane i at the cycle-ending edge.
  - Masked lanes are still visited; for them MemWrite=0 and the RespData lane stays 0.
  - If i==NUM_LANES-1, next state is RESP. Otherwise i increments; the counter never wraps.
- RESP: RespValid=1 and RespData is held stable. On RespReady, next state is IDLE.
- Outside ACCESS: MemWrite=0 and MemAddress=0. MemWriteData=0 outside ACCESS.
- Store batch: RespValid signals completion; RespData is all 0.
- Duplicate addresses in a store batch: the higher-index lane wins because it is issued later.
- Lane counter width is $clog2(NUM_LANES).

## Timing
- Reset values of outputs:
  - ReqReady=1 (IDLE);
  - RespValid=0; RespData=0;
  - MemWrite=0; MemAddress=0; MemWriteData=0.
  - All latched request registers are 0.
- Reset asserted mid-ACCESS aborts the batch immediately:
  - MemWrite drops asynchronously, so no further DataMemory writes occur.
  - Lanes already written stay written.
- Acceptance at edge k (ReqValid & ReqReady):
  - Lane i is presented during cycle k+1+i.
  - Lane i's store commits, or its load is captured, at the end of that cycle.
- RespValid rises in cycle k+NUM_LANES+1. With ReqMask==0, it rises in cycle k+1.
- Minimum request-to-request interval is NUM_LANES+2 cycles: ACCESS, one RESP cycle with RespReady=1, then one IDLE cycle.
- Request inputs are ignored outside IDLE; ReqReady=0 there.
- RespReady while RespValid=0 is ignored.

## Structure
- Shared package tinygpu_mem_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - default widths DATA_WORD_LENGTH=16 and DATAMEM_ADDR_WIDTH=16;
  - default lane count.
- Single module; no sub-module required.
- Lane selection is an indexed part-select on the latched vectors.

## Test plan
- Reset then idle:
  - Stimulus: hold reset for 3 cycles, release, no request.
  - Required: ReqReady=1, RespValid=0, MemWrite=0, MemAddress=0 throughout.
- Full store then full load, NUM_LANES=4:
  - Store: addresses 0x10–0x13, data 0xA000–0xA003, mask 4'b1111. Required: four writes on consecutive cycles, then RespValid in cycle k+5.
  - Load: same addresses. Required: RespData={0xA003,0xA002,0xA001,0xA000}.
- Masked load:
  - Stimulus: mask 4'b0101, addresses holding 0x1111, 0x2222, 0x3333, 0x4444.
  - Required: RespData lanes = 0x1111, 0, 0x3333, 0; MemWrite never 1.
- Empty mask and backpressure:
  - Stimulus: mask 0, RespReady held 0 for 5 cycles.
  - Required: RespValid in cycle k+1 and held with stable RespData; ReqReady=0 until the cycle after RespReady.
- Duplicate-address store:
  - Stimulus: all four lanes to address 0x20, data 1, 2, 3, 4.
  - Required: subsequent load of 0x20 returns 4.
- Reset mid-batch:
  - Stimulus: assert reset during lane 2 of a store to 0x30–0x33.
  - Required: MemWrite drops immediately; 0x30 and 0x31 are written, 0x32 and 0x33 keep their prior contents; IDLE after release.
